// File: rtl/image_pkg.sv
// Shared types and constants for the 3x3 binomial blur stage.
// Holds the kernel weights, rounding constants, pixel struct and FSM states.
package image_pkg;

   localparam int PIX_W   = 8;
   localparam int COORD_W = 11;
   localparam int SUM_W   = 12;
   localparam int SHIFT   = 4;

   localparam logic [SUM_W-1:0] K_CORNER = SUM_W'(1);
   localparam logic [SUM_W-1:0] K_EDGE   = SUM_W'(2);
   localparam logic [SUM_W-1:0] K_CENTER = SUM_W'(4);
   localparam logic [SUM_W-1:0] ROUND    = SUM_W'(8);

   typedef struct packed {
      logic [PIX_W-1:0] r;
      logic [PIX_W-1:0] g;
      logic [PIX_W-1:0] b;
   } pix_t;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   // One channel of the kernel; the sum tops out at 4080 so 12 bits suffice.
   function automatic logic [PIX_W-1:0] mac3x3(
      input logic [PIX_W-1:0] t0, t1, t2,
      input logic [PIX_W-1:0] m0, m1, m2,
      input logic [PIX_W-1:0] b0, b1, b2
   );
      logic [SUM_W-1:0] s;
      s = K_CORNER * SUM_W'(t0) + K_EDGE * SUM_W'(t1) + K_CORNER * SUM_W'(t2)
        + K_EDGE * SUM_W'(m0) + K_CENTER * SUM_W'(m1) + K_EDGE * SUM_W'(m2)
        + K_CORNER * SUM_W'(b0) + K_EDGE * SUM_W'(b1) + K_CORNER * SUM_W'(b2);
      return PIX_W'((s + ROUND) >> SHIFT);
   endfunction

endpackage

// File: rtl/image_blur3x3_line_buffer.sv
// Simple dual-port row store with synchronous read.
// A read and write to the same address in one cycle returns the old word.
module line_buffer #(
   parameter int DEPTH = 1024,
   parameter int DW    = 24,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/image_blur3x3.sv
// Streaming 3x3 binomial blur with border pass-through.
// Two line buffers feed a 3-column window; output lags input by W+1 pixels.
module image_blur3x3
   import image_pkg::*;
#(
   parameter int MAX_WIDTH = 1024
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic [COORD_W-1:0] width,
   input  logic [COORD_W-1:0] height,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic [PIX_W-1:0]   IN_R,
   input  logic [PIX_W-1:0]   IN_G,
   input  logic [PIX_W-1:0]   IN_B,
   output logic               out_valid,
   output logic [COORD_W-1:0] out_row,
   output logic [COORD_W-1:0] out_col,
   output logic [PIX_W-1:0]   OUT_R,
   output logic [PIX_W-1:0]   OUT_G,
   output logic [PIX_W-1:0]   OUT_B,
   output logic               busy,
   output logic               frame_done,
   output logic               drop_err
);

   localparam int AW = $clog2(MAX_WIDTH);
   localparam logic [COORD_W-1:0] C1 = COORD_W'(1);

   state_t state, state_n;
   logic [COORD_W-1:0] w_q, h_q, in_col, in_row;
   logic [COORD_W-1:0] o_col, o_row, col_nxt;
   logic idle_acc, acc, adv, emit, flushing;
   logic in_last_col, o_last_col, out_last, interior;
   logic [AW-1:0] raddr, waddr;
   pix_t in_px, lb0_rd, lb1_rd, blur_px;
   pix_t [2:0] win_a, win_b;

   assign in_px       = {IN_R, IN_G, IN_B};
   assign flushing    = state == FLUSH;
   assign idle_acc    = (state == IDLE) & in_valid & in_sof & ~busy;
   assign acc         = idle_acc | (in_valid & ((state == FILL) | (state == RUN)));
   assign adv         = acc | flushing;
   assign emit        = ((state == RUN) & in_valid) | flushing;
   assign in_last_col = in_col == w_q - C1;
   assign o_last_col  = o_col == w_q - C1;
   assign out_last    = o_last_col & (o_row == h_q - C1);
   assign interior    = (o_row != '0) & (o_row != h_q - C1) & (o_col != '0) & ~o_last_col;

   // Read address runs one column ahead so the sync read lands with the pixel.
   assign col_nxt = idle_acc ? C1 : (in_last_col ? '0 : in_col + C1);
   assign raddr   = AW'(adv ? col_nxt : in_col);
   assign waddr   = AW'(idle_acc ? '0 : in_col);

   line_buffer #(.DEPTH(MAX_WIDTH), .DW($bits(pix_t))) u_lb0 (
      .clk(HCLK), .we(acc), .waddr(waddr), .wdata(in_px),
      .raddr(raddr), .rdata(lb0_rd)
   );

   line_buffer #(.DEPTH(MAX_WIDTH), .DW($bits(pix_t))) u_lb1 (
      .clk(HCLK), .we(acc), .waddr(waddr), .wdata(lb0_rd),
      .raddr(raddr), .rdata(lb1_rd)
   );

   always_comb begin
      blur_px   = '0;
      blur_px.r = mac3x3(win_a[0].r, win_b[0].r, lb1_rd.r,
                         win_a[1].r, win_b[1].r, lb0_rd.r,
                         win_a[2].r, win_b[2].r, in_px.r);
      blur_px.g = mac3x3(win_a[0].g, win_b[0].g, lb1_rd.g,
                         win_a[1].g, win_b[1].g, lb0_rd.g,
                         win_a[2].g, win_b[2].g, in_px.g);
      blur_px.b = mac3x3(win_a[0].b, win_b[0].b, lb1_rd.b,
                         win_a[1].b, win_b[1].b, lb0_rd.b,
                         win_a[2].b, win_b[2].b, in_px.b);
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (idle_acc) state_n = FILL;
         FILL:  if (in_valid & (in_row == C1)) state_n = RUN;
         RUN:   if (in_valid & in_last_col & (in_row == h_q - C1)) state_n = FLUSH;
         FLUSH: if (out_last) state_n = IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (adv) begin
         win_a    <= win_b;
         win_b[0] <= lb1_rd;
         win_b[1] <= lb0_rd;
         win_b[2] <= in_px;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state      <= IDLE;
         w_q        <= '0;
         h_q        <= '0;
         in_col     <= '0;
         in_row     <= '0;
         o_col      <= '0;
         o_row      <= '0;
         out_valid  <= 1'b0;
         out_row    <= '0;
         out_col    <= '0;
         OUT_R      <= '0;
         OUT_G      <= '0;
         OUT_B      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         state      <= state_n;
         out_valid  <= emit;
         frame_done <= emit & out_last;
         drop_err   <= drop_err | (flushing & in_valid);
         if (idle_acc) busy <= 1'b1;
         else if (frame_done) busy <= 1'b0;
         if (adv) in_col <= col_nxt;
         if (idle_acc) begin
            w_q    <= width;
            h_q    <= height;
            in_row <= '0;
            o_row  <= '0;
            o_col  <= '0;
         end else if (acc & in_last_col) begin
            in_row <= in_row + C1;
         end
         if (emit) begin
            out_row <= o_row;
            out_col <= o_col;
            {OUT_R, OUT_G, OUT_B} <= interior ? blur_px : win_b[1];
            if (o_last_col) begin
               o_col <= '0;
               o_row <= o_row + C1;
            end else begin
               o_col <= o_col + C1;
            end
         end
      end
   end

endmodule

// File: tb/tb_image_blur3x3.sv
// Scoreboard bench for image_blur3x3 with directed frames.
// Expected pixels are hand-derived tables pushed before each frame is driven.
module tb_image_blur3x3;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [10:0] width, height;
   logic        in_valid, in_sof;
   logic [7:0]  IN_R, IN_G, IN_B;
   logic        out_valid;
   logic [10:0] out_row, out_col;
   logic [7:0]  OUT_R, OUT_G, OUT_B;
   logic        busy, frame_done, drop_err;

   always #5 HCLK = ~HCLK;

   image_blur3x3 #(.MAX_WIDTH(1024)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .width(width), .height(height),
      .in_valid(in_valid), .in_sof(in_sof),
      .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B),
      .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
      .OUT_R(OUT_R), .OUT_G(OUT_G), .OUT_B(OUT_B),
      .busy(busy), .frame_done(frame_done), .drop_err(drop_err)
   );

   typedef struct packed {
      logic [10:0] row;
      logic [10:0] col;
      logic [23:0] pix;
      logic        done;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [23:0] img [0:3071];
   logic [23:0] xpx [0:3071];
   int          n_chk = 0;
   int          n_fail = 0;
   int          edges = 0;
   int          lat_due = 0;
   bit          chk_lat = 1'b0;

   always @(posedge HCLK) edges <= edges + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented output pops one expected entry.
   always @(negedge HCLK) begin
      if (out_valid) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL stale_output: got row %0d col %0d, expected no output",
                     out_row, out_col);
         end else begin
            mon_e = sbq.pop_front();
            check("out_pixel", {out_row, out_col, OUT_R, OUT_G, OUT_B, frame_done},
                  {mon_e.row, mon_e.col, mon_e.pix, mon_e.done});
            if (chk_lat) begin
               check("first_out_latency", 64'(edges), 64'(lat_due));
               chk_lat = 1'b0;
            end
         end
      end else if (frame_done) begin
         check("done_without_valid", 64'(frame_done), 64'd0);
      end
   end

   task automatic chk_reset_state(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy_done"}, {busy, frame_done}, 64'd0);
      check({tag, "_drop_err"}, 64'(drop_err), 64'd0);
      check({tag, "_coord_pix"}, {out_row, out_col, OUT_R, OUT_G, OUT_B}, 64'd0);
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      @(negedge HCLK);
   endtask

   task automatic push_exp(input int w, input int h);
      exp_t e;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            e.row  = 11'(r);
            e.col  = 11'(c);
            e.pix  = xpx[r * w + c];
            e.done = (r == h - 1) && (c == w - 1);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge HCLK);
         if (frame_done) break;
      end
      if (k == 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL frame_done_timeout: got no frame_done in 3000 cycles, expected one");
      end else begin
         check("busy_at_done", 64'(busy), 64'd1);
         @(negedge HCLK);
         check("busy_after_done", 64'(busy), 64'd0);
      end
   endtask

   task automatic send_frame(input int w, input int h, input int gap_pct,
                             input int junk, input int abort_at, input bit lat);
      push_exp(w, h);
      width  = 11'(w);
      height = 11'(h);
      for (int i = 0; i < w * h; i++) begin
         if (abort_at > 0 && i == abort_at) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            HRESET   = 1'b1;
            @(negedge HCLK);
            @(negedge HCLK);
            sbq.delete();
            chk_reset_state("abort");
            HRESET = 1'b0;
            return;
         end
         if (i > 0) begin
            while ($urandom_range(99) < gap_pct) begin
               in_valid = 1'b0;
               in_sof   = 1'b0;
               @(negedge HCLK);
               check("no_out_on_gap", 64'(out_valid), 64'd0);
            end
         end
         in_valid = 1'b1;
         in_sof   = (i == 0);
         {IN_R, IN_G, IN_B} = img[i];
         if (i == 0) begin
            lat_due = edges + w + 2;
            chk_lat = lat;
         end
         @(negedge HCLK);
      end
      for (int j = 0; j < junk; j++) begin
         in_valid = 1'b1;
         in_sof   = (j == 0);
         {IN_R, IN_G, IN_B} = 24'hABCDEF;
         @(negedge HCLK);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      wait_done();
   endtask

   task automatic set_impulse();
      for (int i = 0; i < 25; i++) begin
         img[i] = '0;
         xpx[i] = '0;
      end
      img[12] = {8'd160, 16'd0};
      xpx[6]  = {8'd10, 16'd0};
      xpx[7]  = {8'd20, 16'd0};
      xpx[8]  = {8'd10, 16'd0};
      xpx[11] = {8'd20, 16'd0};
      xpx[12] = {8'd40, 16'd0};
      xpx[13] = {8'd20, 16'd0};
      xpx[16] = {8'd10, 16'd0};
      xpx[17] = {8'd20, 16'd0};
      xpx[18] = {8'd10, 16'd0};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish by 1000000, expected earlier finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ramp [0:8];
      ramp = '{8'd0, 8'd32, 8'd64, 8'd96, 8'd128, 8'd160, 8'd192, 8'd224, 8'd255};
      HRESET   = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      {IN_R, IN_G, IN_B} = '0;
      width    = '0;
      height   = '0;
      repeat (3) @(negedge HCLK);
      chk_reset_state("reset");
      HRESET = 1'b0;
      @(negedge HCLK);

      for (int i = 0; i < 12; i++) begin
         img[i] = {8'd100, 8'd100, 8'd100};
         xpx[i] = img[i];
      end
      send_frame(4, 3, 0, 0, 0, 1'b1);
      check("drop_err_clean", 64'(drop_err), 64'd0);

      set_impulse();
      send_frame(5, 5, 0, 0, 0, 1'b0);
      send_frame(5, 5, 30, 0, 0, 1'b0);
      send_frame(5, 5, 0, 2, 0, 1'b0);
      check("drop_err_set", 64'(drop_err), 64'd1);
      repeat (3) idle_cycle();
      check("drop_err_sticky", 64'(drop_err), 64'd1);

      send_frame(5, 5, 0, 0, 12, 1'b0);
      repeat (8) idle_cycle();

      for (int i = 0; i < 9; i++) begin
         img[i] = {ramp[i], 8'd255, (i == 4) ? 8'd2 : 8'd0};
         xpx[i] = img[i];
      end
      xpx[4] = {8'd128, 8'd255, 8'd1};
      send_frame(3, 3, 0, 0, 0, 1'b0);

      for (int c = 0; c < 1024; c++) begin
         img[c]        = {8'd0, 8'd255, 8'd8};
         img[1024 + c] = {8'd0, 8'd255, 8'd0};
         img[2048 + c] = {8'd240, 8'd255, 8'd0};
         xpx[c]        = img[c];
         xpx[1024 + c] = (c == 0 || c == 1023) ? img[1024 + c] : {8'd60, 8'd255, 8'd2};
         xpx[2048 + c] = img[2048 + c];
      end
      send_frame(1024, 3, 0, 0, 0, 1'b1);

      repeat (5) idle_cycle();
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      check("drop_err_end", 64'(drop_err), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
